twos_complement_sequential_divider: RTL and testbench
=====================================================

Name: twos_complement_sequential_divider

Overview:
- Multi-cycle signed (two's complement) integer divider; the inverse operation of the team's combinational two's-complement multiplier.
- Restoring shift-subtract on operand magnitudes, one quotient bit per clock, followed by a sign-correction cycle.
- Sits beside the multiplier in the arithmetic datapath and is driven by a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed dividend, sampled on the accept edge
- divisor  input  WIDTH  signed divisor, sampled on the accept edge
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; results valid from this cycle onward
- quotient  output  WIDTH  signed quotient
- remainder  output  WIDTH  signed remainder
- div_by_zero  output  1  divisor was 0 for the last result
- overflow  output  1  dividend = most-negative value and divisor = -1 for the last result

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: state IDLE. busy, done, quotient, remainder, div_by_zero and overflow are all 0.
- rst asserted mid-operation aborts the operation. The next edge forces the reset values, and the in-flight result is discarded.
- States:
  - IDLE: busy = 0. If start = 1, the edge (edge 0) latches the dividend and divisor magnitudes as WIDTH-bit unsigned values, latches both sign bits and the zero/overflow conditions, loads the counter with WIDTH, and moves to CALC.
  - CALC: busy = 1. Each edge performs one iteration: shift the {partial remainder, quotient} pair left by 1. Then compute a trial subtract, partial remainder minus divisor magnitude, in WIDTH+1 bits. If the trial result is non-negative, keep it and set quotient bit = 1; otherwise restore and set quotient bit = 0. The counter decrements each edge. The edge on which the counter reaches 0 (edge WIDTH) moves to FIX.
  - FIX: busy = 1. Edge WIDTH+1 does the following, then moves to IDLE:
    - Negate the quotient magnitude if the two sign bits differ.
    - Negate the remainder magnitude if the dividend was negative.
    - Register quotient, remainder, div_by_zero and overflow.
    - Assert done for exactly one cycle.
- Latency: fixed WIDTH+1 edges from the accept edge to done, for all operands including the error cases.
- busy falls on the same edge that done rises.
- Semantics are truncation toward zero:
  - sign(remainder) = sign(dividend)
  - |remainder| < |divisor|
  - dividend = quotient*divisor + remainder, mod 2^WIDTH
- Magnitude of the most-negative value is 2^(WIDTH-1), held exactly in WIDTH unsigned bits.
- Divide by zero: the full latency still elapses. Results are quotient = all ones (-1), remainder = dividend, div_by_zero = 1, overflow = 0.
- Overflow (most-negative / -1): quotient wraps to the most-negative value, remainder = 0, overflow = 1.
- start while busy is ignored, with no queueing.
- start high in the done cycle (state is IDLE) is accepted on that edge, giving back-to-back operation.
- Result outputs and flags hold their value until the next FIX edge or reset.
- Changes on dividend or divisor after the accept edge have no effect.

Decomposition:
- Shared package/header: state encoding constants (IDLE, CALC, FIX) and the default WIDTH; the multiplier and divider both use them.
- One sub-module: ripple_add_sub, a WIDTH+1-bit ripple adder/subtractor built from full-adder cells.
  - Inputs: a, b, sub.
  - Outputs: result and carry; sub=1 inverts b and sets carry-in to 1.
  - Used for the trial subtract and, time-shared in FIX, for the negations.
- Counter width: clog2(WIDTH+1).

Test Plan (WIDTH = 8):
- 100 / 7, start pulsed at edge 0 -> busy high edges 1..8; done high only in the cycle after edge 9; quotient = 0x0E (14), remainder = 0x02, both flags 0.
- -100 / 7 -> quotient = 0xF2 (-14), remainder = 0xFE (-2); then 100 / -7 -> quotient = 0xF2, remainder = 0x02; then -100 / -7 -> quotient = 0x0E, remainder = 0xFE.
- -128 / -1 -> quotient = 0x80, remainder = 0x00, overflow = 1. Then -128 / 1 -> quotient = 0x80, remainder = 0, overflow = 0.
- 5 / 0 -> done after the full 9-edge latency; quotient = 0xFF, remainder = 0x05, div_by_zero = 1.
- Handshake: start held high continuously across 3 operations (127/2, 1/3, -1/1) -> inputs changed mid-CALC are ignored. Results are 63 r1, 0 r1, and -1 r0, each done exactly 9 edges after its accept edge, with no idle gap.
- rst asserted at edge 4 of an operation -> next edge all outputs = 0, state IDLE, no done pulse. A following 9 / 3 then completes normally with quotient = 3, remainder = 0.

Source files
------------

// File: rtl/twos_complement_sequential_divider_pkg.sv
// Shared arithmetic-datapath definitions.
// Used by the two's-complement multiplier and divider.
package twos_complement_sequential_divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/twos_complement_sequential_divider_ripple_add_sub.sv
// WIDTH+1-bit ripple-carry adder/subtractor.
// sub=1 computes a - b by inverting b and forcing carry-in.
module ripple_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] result,
  output logic           carry
);

  logic [WIDTH+1:0] c;
  logic [WIDTH:0]   bx;

  assign bx   = b ^ {(WIDTH+1){sub}};
  assign c[0] = sub;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign result[i] = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]    = (a[i] & bx[i])
                     | (c[i] & (a[i] ^ bx[i]));
  end

  assign carry = c[WIDTH+1];

endmodule

// File: rtl/twos_complement_sequential_divider.sv
// Signed restoring divider: one quotient bit per clock,
// then a sign-correction cycle. Truncates toward zero.
module twos_complement_sequential_divider
  import twos_complement_sequential_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dmag;
  logic             sa;
  logic             sb;
  logic             dz;
  logic             ov;

  logic [WIDTH:0]   a_t;
  logic [WIDTH:0]   b_t;
  logic [WIDTH:0]   r_t;
  logic [WIDTH:0]   r_n;
  logic             c_t;
  logic             c_n;
  logic             nonneg;
  logic             unused_bits;

  // Trial adder doubles as the quotient negator in FIX.
  always_comb begin
    a_t = {rem, q[WIDTH-1]};
    b_t = {1'b0, dmag};
    if (state == FIX) begin
      a_t = '0;
      b_t = {1'b0, q};
    end
  end

  ripple_add_sub #(.WIDTH(WIDTH)) u_trial (
    .a      (a_t),
    .b      (b_t),
    .sub    (1'b1),
    .result (r_t),
    .carry  (c_t)
  );

  ripple_add_sub #(.WIDTH(WIDTH)) u_neg (
    .a      ('0),
    .b      ({1'b0, rem}),
    .sub    (1'b1),
    .result (r_n),
    .carry  (c_n)
  );

  assign nonneg      = ~r_t[WIDTH];
  assign unused_bits = ^{c_t, c_n, r_n[WIDTH]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      q           <= '0;
      dmag        <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            q     <= dividend[WIDTH-1] ? -dividend : dividend;
            dmag  <= divisor[WIDTH-1] ? -divisor : divisor;
            sa    <= dividend[WIDTH-1];
            sb    <= divisor[WIDTH-1];
            dz    <= (divisor == '0);
            ov    <= (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                  && (divisor == '1);
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rem <= nonneg ? r_t[WIDTH-1:0] : a_t[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], nonneg};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient    <= dz        ? '1
                       : (sa ^ sb) ? r_t[WIDTH-1:0]
                       :             q;
          remainder   <= sa ? r_n[WIDTH-1:0] : rem;
          div_by_zero <= dz;
          overflow    <= ov;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_twos_complement_sequential_divider.sv
// Randomized scoreboard bench for the signed divider.
// Expected results come from plain integer / and %.
module tb_twos_complement_sequential_divider;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           acc;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  twos_complement_sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int           cyc = 0;
  int           checks = 0;
  int           passed = 0;
  exp_t         sb[$];
  exp_t         me;
  logic         exp_busy;
  logic [W-1:0] lq = '0;
  logic [W-1:0] lr = '0;
  logic         ldz = 1'b0;
  logic         lov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  n, act, want, cyc);
  endtask

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int x = int'($signed(a));
    int y = int'($signed(b));
    int qi;
    int ri;
    e.acc = 0;
    e.due = 0;
    if (y == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
      e.ov = 1'b0;
    end else begin
      qi   = x / y;
      ri   = x % y;
      e.q  = qi[W-1:0];
      e.r  = ri[W-1:0];
      e.dz = 1'b0;
      e.ov = (x == -(1 << (W-1))) && (y == -1);
    end
    return e;
  endfunction

  // Monitor: pops and compares whenever done is seen.
  always @(posedge clk) begin
    #1;
    exp_busy = 1'b0;
    foreach (sb[i])
      if (sb[i].acc <= cyc && cyc < sb[i].due) exp_busy = 1'b1;
    chk("busy", busy, exp_busy);
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", done, 1'b0);
      end else begin
        me = sb.pop_front();
        chk("latency", cyc, me.due);
        chk("quotient", quotient, me.q);
        chk("remainder", remainder, me.r);
        chk("div_by_zero", div_by_zero, me.dz);
        chk("overflow", overflow, me.ov);
        lq = me.q; lr = me.r; ldz = me.dz; lov = me.ov;
      end
    end else begin
      if (sb.size() > 0 && cyc >= sb[0].due) begin
        me = sb.pop_front();
        chk("missing_done", done, 1'b1);
        lq = me.q; lr = me.r; ldz = me.dz; lov = me.ov;
      end
      chk("hold_quotient", quotient, lq);
      chk("hold_remainder", remainder, lr);
      chk("hold_flags", {div_by_zero, overflow}, {ldz, lov});
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(a, b);
    e.acc = cyc + 1;
    e.due = cyc + 10;
    sb.push_back(e);
  endtask

  // mode 0: quiet, 1: random ignored starts, 2: start held high
  task automatic op(input int a, input int b, input int mode);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    push(dividend, divisor);
    repeat (9) begin
      @(negedge clk);
      dividend = W'($urandom);
      divisor  = W'($urandom);
      start    = (mode == 2) ? 1'b1
               : (mode == 1) ? 1'($urandom_range(0, 1))
               : 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic int pick();
    unique case ($urandom_range(0, 6))
      0:       return 0;
      1:       return 1;
      2:       return -1;
      3:       return -128;
      4:       return 127;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    op(100, 7, 0);
    op(-100, 7, 0);
    op(100, -7, 0);
    op(-100, -7, 0);
    op(-128, -1, 0);
    op(-128, 1, 0);
    op(5, 0, 0);
    op(127, 2, 2);
    op(1, 3, 2);
    op(-1, 1, 2);
    idle(2);

    // Abort mid-operation with a reset at edge 4.
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(50);
    divisor  = W'(3);
    push(dividend, divisor);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    lq = '0; lr = '0; ldz = 1'b0; lov = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_quotient", quotient, '0);
    chk("rst_remainder", remainder, '0);
    chk("rst_flags", {div_by_zero, overflow}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    op(9, 3, 0);
    idle(1);

    repeat (80) begin
      op(pick(), pick(), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(15);
    if (sb.size() != 0)
      chk("scoreboard_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
